// File: rtl/enum_type.sv
// Shared types and constants for the scoring stage.
package enum_type;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    D0   = 3'd1,
    D1   = 3'd2,
    D2   = 3'd3,
    D3   = 3'd4
  } score_fsm_t;

  // BCD points awarded for a line-clear event; zero for out-of-range counts.
  function automatic logic [7:0] line_points(input logic [2:0] lines);
    case (lines)
      3'd1:    line_points = 8'h01;
      3'd2:    line_points = 8'h03;
      3'd3:    line_points = 8'h05;
      3'd4:    line_points = 8'h08;
      default: line_points = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with carry; time-shared across the four score digits.
module bcd_digit_add (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin_i};
    if (raw > 5'd9) begin
      sum_o  = 4'(raw - 5'd10);
      cout_o = 1'b1;
    end else begin
      sum_o  = raw[3:0];
      cout_o = 1'b0;
    end
  end

endmodule

// File: rtl/score_counter.sv
// Line-clear scoring: serial BCD accumulation, one-entry pending buffer, saturating line total.
//   state | meaning
//   IDLE  | no event in flight
//   D0-D3 | adding points digit n into the working copy; D3 commits
module score_counter
  import enum_type::*;
#(
  parameter int unsigned MAX_LINES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_start,
  input  logic        clear_valid,
  input  logic [2:0]  clear_lines,
  output logic [15:0] score,
  output logic        score_inc,
  output logic [9:0]  lines_total,
  output logic        busy,
  output logic        overflow
);

  localparam logic [10:0] MaxLines = 11'(MAX_LINES);

  score_fsm_t  state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [15:0] work_q, work_d;
  logic        carry_q, carry_d;
  logic [2:0]  cur_q, cur_d;
  logic [2:0]  pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic [9:0]  lines_q, lines_d;
  logic        inc_q, inc_d;
  logic        ovf_q, ovf_d;

  logic [7:0]  pts;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic [10:0] lines_sum;
  logic        ev_ok;

  bcd_digit_add u_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign ev_ok = clear_valid && (clear_lines != 3'd0) && (clear_lines <= 3'd4);

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    work_d    = work_q;
    carry_d   = carry_q;
    cur_d     = cur_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    lines_d   = lines_q;
    inc_d     = 1'b0;
    ovf_d     = ovf_q;
    add_a     = 4'd0;
    add_b     = 4'd0;
    add_cin   = 1'b0;
    pts       = line_points(cur_q);
    lines_sum = {1'b0, lines_q} + {8'd0, cur_q};

    case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          state_d  = D0;
          cur_d    = pend_q;
          pend_v_d = 1'b0;
        end else if (ev_ok) begin
          state_d = D0;
          cur_d   = clear_lines;
        end
      end
      D0: begin
        // D0 reads the committed score directly, so a back-to-back event sees the fresh commit.
        add_a   = score_q[3:0];
        add_b   = pts[3:0];
        work_d  = {score_q[15:4], add_sum};
        carry_d = add_cout;
        state_d = D1;
      end
      D1: begin
        add_a       = work_q[7:4];
        add_b       = pts[7:4];
        add_cin     = carry_q;
        work_d[7:4] = add_sum;
        carry_d     = add_cout;
        state_d     = D2;
      end
      D2: begin
        add_a        = work_q[11:8];
        add_cin      = carry_q;
        work_d[11:8] = add_sum;
        carry_d      = add_cout;
        state_d      = D3;
      end
      D3: begin
        add_a   = work_q[15:12];
        add_cin = carry_q;
        inc_d   = 1'b1;
        score_d = add_cout ? 16'h9999 : {add_sum, work_q[11:0]};
        lines_d = (lines_sum > MaxLines) ? MaxLines[9:0] : lines_sum[9:0];
        if (pend_v_q) begin
          state_d  = D0;
          cur_d    = pend_q;
          pend_v_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pending slot is free if empty, or if it is being consumed this cycle.
    if (ev_ok && !(state_q == IDLE && !pend_v_q)) begin
      if (!pend_v_q || state_q == IDLE || state_q == D3) begin
        pend_d   = clear_lines;
        pend_v_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || game_start) begin
      state_q  <= IDLE;
      score_q  <= 16'h0000;
      work_q   <= 16'h0000;
      carry_q  <= 1'b0;
      cur_q    <= 3'd0;
      pend_q   <= 3'd0;
      pend_v_q <= 1'b0;
      lines_q  <= 10'd0;
      inc_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      work_q   <= work_d;
      carry_q  <= carry_d;
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      lines_q  <= lines_d;
      inc_q    <= inc_d;
      ovf_q    <= ovf_d;
    end
  end

  assign score       = score_q;
  assign score_inc   = inc_q;
  assign lines_total = lines_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q != IDLE) || pend_v_q;

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: event-timing reference model checked every cycle, plus pinned directed cases.
module tb_score_counter;

  localparam int MAXL = 1023;

  logic        clk = 1'b0;
  logic        rst, game_start, clear_valid;
  logic [2:0]  clear_lines;
  logic [15:0] score;
  logic        score_inc, busy, overflow;
  logic [9:0]  lines_total;

  score_counter #(.MAX_LINES(MAXL)) dut (
    .clk         (clk),
    .rst         (rst),
    .game_start  (game_start),
    .clear_valid (clear_valid),
    .clear_lines (clear_lines),
    .score       (score),
    .score_inc   (score_inc),
    .lines_total (lines_total),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: decimal score, event finishes 4 cycles after it starts.
  int m_score, m_lines, m_done, m_cur, m_pend;
  bit m_inc, m_ovf, m_fly, m_pv;

  function automatic int pts_of(input int n);
    case (n)
      1: return 1;
      2: return 3;
      3: return 5;
      4: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) begin
    bit old_fly, old_pv;
    int l;
    m_inc = 0;
    if (rst || game_start) begin
      m_score = 0; m_lines = 0; m_ovf = 0; m_fly = 0; m_pv = 0;
    end else begin
      old_fly = m_fly;
      old_pv  = m_pv;
      if (m_fly && m_done == cyc) begin
        m_score = (m_score + pts_of(m_cur) > 9999) ? 9999 : m_score + pts_of(m_cur);
        m_lines = (m_lines + m_cur > MAXL) ? MAXL : m_lines + m_cur;
        m_inc = 1;
        m_fly = 0;
      end
      if (old_pv && (!old_fly || m_done == cyc)) begin
        m_fly = 1; m_cur = m_pend; m_done = cyc + 4; m_pv = 0;
      end
      l = int'(clear_lines);
      if (clear_valid && l >= 1 && l <= 4) begin
        if (!old_fly && !old_pv) begin
          m_fly = 1; m_cur = l; m_done = cyc + 4;
        end else if (!m_pv) begin
          m_pv = 1; m_pend = l;
        end else begin
          m_ovf = 1;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("score", 32'(score), 32'(to_bcd(m_score)));
      chk("score_inc", 32'(score_inc), 32'(m_inc));
      chk("lines_total", 32'(lines_total), 32'(m_lines));
      chk("busy", 32'(busy), 32'(m_fly || m_pv));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_game();
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
  endtask

  task automatic send(input int l, output bit seen);
    seen = 1'b0;
    clear_valid = 1'b1;
    clear_lines = 3'(l);
    tick();
    clear_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (score_inc) seen = 1'b1;
      if (seen && !busy) break;
    end
    chk("send_done", 32'(seen && !busy), 32'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; game_start = 1'b0; clear_valid = 1'b0; clear_lines = 3'd0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_inc", 32'(score_inc), 32'h0);
    chk("rst_lines", 32'(lines_total), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);

    // 4-line event at cycle 0: commit visible at cycle 5
    clear_valid = 1'b1; clear_lines = 3'd4;
    tick();
    clear_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("lat_inc", 32'(score_inc), 32'(k == 5));
      if (k == 5) begin
        chk("lat_score", 32'(score), 32'h0008);
        chk("lat_lines", 32'(lines_total), 32'd4);
      end
      tick();
    end

    // three consecutive events: second goes pending, third dropped
    new_game();
    clear_valid = 1'b1; clear_lines = 3'd1; tick();
    clear_lines = 3'd2; tick();
    clear_lines = 3'd3; tick();
    clear_valid = 1'b0;
    tick(); tick();
    chk("b2b_inc1", 32'(score_inc), 32'd1);
    chk("b2b_score1", 32'(score), 32'h0001);
    tick(); tick(); tick();
    chk("b2b_gap", 32'(score_inc), 32'd0);
    tick();
    chk("b2b_inc2", 32'(score_inc), 32'd1);
    chk("b2b_score2", 32'(score), 32'h0004);
    chk("b2b_lines", 32'(lines_total), 32'd3);
    chk("b2b_ovf", 32'(overflow), 32'd1);

    // out-of-range line counts are ignored
    new_game();
    clear_valid = 1'b1; clear_lines = 3'd0; tick();
    clear_lines = 3'd5; tick();
    clear_valid = 1'b0;
    repeat (6) tick();
    chk("ign_score", 32'(score), 32'h0);
    chk("ign_lines", 32'(lines_total), 32'd0);
    chk("ign_busy", 32'(busy), 32'd0);
    chk("ign_ovf", 32'(overflow), 32'd0);

    // game_start while D2 is active
    send(4, seen);
    chk("gs_pre", 32'(score), 32'h0008);
    clear_valid = 1'b1; clear_lines = 3'd3; tick();
    clear_valid = 1'b0;
    tick(); tick();
    game_start = 1'b1; tick();
    game_start = 1'b0;
    chk("gs_busy", 32'(busy), 32'd0);
    chk("gs_score", 32'(score), 32'h0);
    repeat (5) tick();
    chk("gs_nocommit", 32'(score), 32'h0);

    // carry through digits 1 and 2
    new_game();
    repeat (12) send(4, seen);
    send(2, seen);
    chk("c99_pre", 32'(score), 32'h0099);
    send(2, seen);
    chk("c99_score", 32'(score), 32'h0102);
    chk("c99_lines", 32'(lines_total), 32'd52);

    // saturation at 9999 and at MAX_LINES
    new_game();
    repeat (1249) send(4, seen);
    send(2, seen);
    chk("sat_pre", 32'(score), 32'h9995);
    send(4, seen);
    chk("sat_score", 32'(score), 32'h9999);
    chk("sat_inc", 32'(seen), 32'd1);
    send(1, seen);
    chk("sat_score2", 32'(score), 32'h9999);
    chk("sat_inc2", 32'(seen), 32'd1);
    chk("sat_lines", 32'(lines_total), 32'd1023);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 499) == 0);
      game_start  = ($urandom_range(0, 199) == 0);
      clear_valid = ($urandom_range(0, 9) < 4);
      clear_lines = 3'($urandom_range(0, 5));
      tick();
    end
    rst = 1'b0; game_start = 1'b0; clear_valid = 1'b0;
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/score_counter.md
# score_counter

Upstream scoring stage for the Tetris datapath. Accepts line-clear events from the board engine, converts them to points, and accumulates a 4-digit BCD score and a saturating line total. Produces the `score` word and one-cycle `score_inc` pulse that the control stage uses for speed scaling (`score_pow`) and countdown extension. BCD addition is serial, one digit per cycle, behind a one-entry pending buffer.

## Interface
Parameters:
- `MAX_LINES`, 1023: saturation value of `lines_total`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `game_start`  in  1  one-cycle pulse; clears score state for a new game.
- `clear_valid`  in  1  one-cycle pulse; a line-clear event is present.
- `clear_lines`  in  3  lines cleared by the event; valid range 1..4.
- `score`  out  16  BCD score, digit 0 in [3:0]; range 0000..9999.
- `score_inc`  out  1  one-cycle pulse when a new score is committed.
- `lines_total`  out  10  binary count of cleared lines, saturating at `MAX_LINES`.
- `busy`  out  1  FSM not in IDLE, or pending buffer full.
- `overflow`  out  1  sticky: an event was dropped.

## Operation
- Points per event (BCD): 1 line → 01, 2 → 03, 3 → 05, 4 → 08. An event with `clear_lines` of 0 or >4 is ignored: no pending entry, no `score_inc`, no line count, and no `overflow`.
- FSM states are IDLE, D0, D1, D2, D3.
  - IDLE + valid event → D0.
  - Dn adds points digit n plus carry into a working copy of the score. Points digit 1 is 0 for every event. Dn → Dn+1.
  - D3 commits the working copy to `score`. It then goes to D0 if pending is full (consuming it), else to IDLE.
- BCD digit add: sum = a + b + cin. If sum > 9, the digit is sum − 10 and cout is 1.
- Carry out of digit 3 saturates the committed score to 9999. Once the score is 9999, later events still pulse `score_inc`.
- `lines_total` increments by `clear_lines` at commit, saturating at `MAX_LINES`.
- Pending buffer holds one event (the line count).
  - A valid event arriving while not IDLE goes to pending if pending is empty.
  - In D3 with pending full, pending is consumed that cycle, so a coincident valid event is stored into pending.
  - Any other valid event is dropped and sets `overflow`.
- `game_start` has priority over `clear_valid` in the same cycle; that event is discarded. It clears `score`, `lines_total`, working copy, pending and `overflow`, and forces IDLE. `score_inc` is not asserted.
- `rst` has the same effect as `game_start`.

## Timing
- Reset values: `score`=0, `score_inc`=0, `lines_total`=0, `busy`=0, `overflow`=0, FSM=IDLE, pending empty.
- Event sampled in IDLE at cycle t: D0..D3 occupy cycles t+1..t+4. The new `score`, new `lines_total` and `score_inc`=1 all appear together in cycle t+5. Latency is 5 cycles.
- Back-to-back: with pending full at D3, the next D0 runs in the same cycle that `score_inc` is high. Committed events are therefore spaced 4 cycles apart.
- `score` changes only at commit; it never shows a partially added value.
- `busy` is registered and is high from cycle t+1 through the last D3 cycle.
- `game_start` or `rst` mid-operation (any Dn): the in-flight event is discarded and nothing is committed. Outputs equal reset values in the following cycle.

## Structure
- Shared package `enum_type` gains:
  - `score_fsm_t` (IDLE, D0..D3);
  - constant function `line_points(lines)` returning 8-bit BCD points.
- Sub-module `bcd_digit_add`: combinational 4-bit digit plus 4-bit digit plus carry-in, producing digit and carry-out. Instantiated once and time-multiplexed across digits by the FSM.
- Top-level contents: registers, FSM, pending buffer, saturation logic.

## Test plan
- Reset, then `clear_lines`=4 at cycle 0 → `score`=0008, `score_inc` high only in cycle 5, `lines_total`=4.
- Score 0099, event of 2 lines → 0102. Carry propagates through digits 1 and 2.
- Score 9995, 4-line event → 9999 with `score_inc`. A further 1-line event → 9999, `score_inc` pulses again.
- Three events on consecutive cycles (lines 1,2,3) → first and second commit 4 cycles apart (0001, 0004), third dropped, `overflow`=1, `lines_total`=3.
- `clear_lines`=0 and 5 → no change, no `score_inc`. `game_start` during D2 → `score`=0, no commit, `busy`=0 the next cycle.
